// File: rtl/lissajous_osc_seq_if.sv
// Bus between the oscillator sequencer and the shared signed 16x16 multiply-add stage.
// The master drives the operands, addend and add/subtract select; the slave returns the
// 32-bit result one cycle after it registers the operands.
interface lissajous_osc_seq_if;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [31:0] mac_s;
  logic        mac_sub;
  logic [31:0] mac_y;

  modport master (
    output mac_a,
    output mac_b,
    output mac_s,
    output mac_sub,
    input  mac_y
  );

  modport slave (
    input  mac_a,
    input  mac_b,
    input  mac_s,
    input  mac_sub,
    output mac_y
  );
endinterface

// File: rtl/lissajous_osc_seq.sv
// Magic-circle quadrature oscillator sequencer.
// Each accepted tick runs x' = x - e*y, y' = y + e*x' on one shared multiply-add stage,
// issuing two operations and producing one (x, y) update with a single-cycle valid pulse.
// Optional build macro LISSAJOUS_OSC_SAT_EN: result formatting saturates instead of wrapping.
module lissajous_osc_seq #(
  parameter logic [15:0] X_INIT = 16'h6000,
  parameter logic [15:0] Y_INIT = 16'h0000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tick,
  input  logic [15:0]                freq,
  input  logic                       load,
  input  logic [15:0]                x0,
  input  logic [15:0]                y0,
  input  logic                       clear,
  output logic [15:0]                x,
  output logic [15:0]                y,
  output logic                       valid,
  output logic                       busy,
  output logic                       overrun,
  lissajous_osc_seq_if.master        mac
);

  typedef enum logic [2:0] {
    StIdle,
    StIssueX,
    StWaitX,
    StIssueY,
    StWaitY
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] e_q, e_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] xn_q, xn_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic [15:0] mac_a_q, mac_a_d;
  logic [15:0] mac_b_q, mac_b_d;
  logic [31:0] mac_s_q, mac_s_d;
  logic        mac_sub_q, mac_sub_d;

  // Q2.30 product-sum back to Q1.15; only ever sampled into a flop.
  logic [15:0] fmt_y;
  logic        unused_mac_y;

`ifdef LISSAJOUS_OSC_SAT_EN
  // Saturating format: clamp when the two top result bits disagree.
  always_comb begin
    fmt_y = mac.mac_y[30:15];
    if (mac.mac_y[31] != mac.mac_y[30]) begin
      fmt_y = mac.mac_y[31] ? 16'h8000 : 16'h7fff;
    end
  end
  assign unused_mac_y = ^mac.mac_y[14:0];
`else
  // Wrapping format: plain truncation toward minus infinity.
  assign fmt_y = mac.mac_y[30:15];
  assign unused_mac_y = ^{mac.mac_y[31], mac.mac_y[14:0]};
`endif

  // Next-state: FSM sequencing, operand loading, load override and sticky overrun.
  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    x_d       = x_q;
    y_d       = y_q;
    xn_d      = xn_q;
    valid_d   = 1'b0;
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    mac_s_d   = mac_s_q;
    mac_sub_d = mac_sub_q;

    // A tick that arrives mid-step is lost; a simultaneous load swallows it silently.
    overrun_d = (overrun_q & ~clear) | (tick & ~load & (state_q != StIdle));

    if (load) begin
      x_d     = x0;
      y_d     = y0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            e_d       = freq;
            mac_a_d   = freq;
            mac_b_d   = y_q;
            mac_s_d   = {x_q[15], x_q, 15'b0};
            mac_sub_d = 1'b1;
            state_d   = StIssueX;
          end
        end
        StIssueX: state_d = StWaitX;
        StWaitX: begin
          xn_d      = fmt_y;
          mac_a_d   = e_q;
          mac_b_d   = fmt_y;
          mac_s_d   = {y_q[15], y_q, 15'b0};
          mac_sub_d = 1'b0;
          state_d   = StIssueY;
        end
        StIssueY: state_d = StWaitY;
        StWaitY: begin
          x_d     = xn_q;
          y_d     = fmt_y;
          valid_d = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      e_q       <= 16'h0000;
      x_q       <= X_INIT;
      y_q       <= Y_INIT;
      xn_q      <= 16'h0000;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      mac_a_q   <= 16'h0000;
      mac_b_q   <= 16'h0000;
      mac_s_q   <= 32'h0000_0000;
      mac_sub_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      x_q       <= x_d;
      y_q       <= y_d;
      xn_q      <= xn_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      mac_s_q   <= mac_s_d;
      mac_sub_q <= mac_sub_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign valid       = valid_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;
  assign mac.mac_a   = mac_a_q;
  assign mac.mac_b   = mac_b_q;
  assign mac.mac_s   = mac_s_q;
  assign mac.mac_sub = mac_sub_q;

endmodule

// File: tb/tb_lissajous_osc_seq.sv
// Bench for lissajous_osc_seq: models the downstream multiply-add stage, runs directed
// scenarios and a randomized phase against a step-level reference of the recursion.
module tb_lissajous_osc_seq;

  localparam logic [15:0] XI = 16'h6000;
  localparam logic [15:0] YI = 16'h0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] freq = 16'h0;
  logic [15:0] x0 = 16'h0;
  logic [15:0] y0 = 16'h0;
  logic [15:0] x;
  logic [15:0] y;
  logic        valid;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  lissajous_osc_seq_if mac_bus ();

  lissajous_osc_seq dut (
    .clock   (clock),
    .reset   (reset),
    .tick    (tick),
    .freq    (freq),
    .load    (load),
    .x0      (x0),
    .y0      (y0),
    .clear   (clear),
    .x       (x),
    .y       (y),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun),
    .mac     (mac_bus)
  );

  // Downstream stage: operands registered, signed result valid one cycle later.
  logic signed [15:0] st_a = '0;
  logic signed [15:0] st_b = '0;
  logic signed [31:0] st_s = '0;
  logic               st_sub = 1'b0;
  logic signed [31:0] st_prod;

  always_ff @(posedge clock) begin
    st_a   <= mac_bus.mac_a;
    st_b   <= mac_bus.mac_b;
    st_s   <= mac_bus.mac_s;
    st_sub <= mac_bus.mac_sub;
  end
  assign st_prod = st_a * st_b;
  assign mac_bus.mac_y = st_sub ? (st_s - st_prod) : (st_s + st_prod);

  // Reference model state.
  logic [15:0] m_x = XI;
  logic [15:0] m_y = YI;
  logic [15:0] p_x = '0;
  logic [15:0] p_y = '0;
  int          m_cnt = 0;
  logic        m_valid = 1'b0;
  logic        m_ov = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Q2.30 value (wrapped to the 32-bit stage width) back to Q1.15.
  function automatic logic [15:0] fmt_ref(input longint r);
    longint w;
    longint q;
    w = r & 64'h0000_0000_ffff_ffff;
    if (w >= 64'sh8000_0000) w = w - 64'sh1_0000_0000;
    q = w >>> 15;
`ifdef LISSAJOUS_OSC_SAT_EN
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`endif
    return q[15:0];
  endfunction

  task automatic ref_step(input logic [15:0] xs, input logic [15:0] ys, input logic [15:0] e,
                          output logic [15:0] xn, output logic [15:0] yn);
    longint lx;
    longint ly;
    longint le;
    lx = longint'($signed(xs));
    ly = longint'($signed(ys));
    le = longint'($signed(e));
    xn = fmt_ref(lx * 32768 - le * ly);
    yn = fmt_ref(ly * 32768 + le * longint'($signed(xn)));
  endtask

  // One clock: drive inputs, advance model at the edge, compare outputs just after it.
  task automatic cyc(input logic rst_n, input logic t, input logic ld, input logic clr,
                     input logic [15:0] f, input logic [15:0] a0, input logic [15:0] b0);
    reset = rst_n;
    tick  = t;
    load  = ld;
    clear = clr;
    freq  = f;
    x0    = a0;
    y0    = b0;
    @(posedge clock);
    if (!rst_n) begin
      m_x = XI;
      m_y = YI;
      m_cnt = 0;
      m_valid = 1'b0;
      m_ov = 1'b0;
    end else begin
      m_ov = (m_ov && !clr) || (t && !ld && m_cnt != 0);
      m_valid = 1'b0;
      if (ld) begin
        m_x = a0;
        m_y = b0;
        m_cnt = 0;
      end else if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_x = p_x;
          m_y = p_y;
          m_valid = 1'b1;
        end
      end else if (t) begin
        ref_step(m_x, m_y, f, p_x, p_y);
        m_cnt = 4;
      end
    end
    #1;
    check("x", 32'(x), 32'(m_x));
    check("y", 32'(y), 32'(m_y));
    check("valid", 32'(valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_cnt != 0));
    check("overrun", 32'(overrun), 32'(m_ov));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    // Reset state.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    check("rst_x", 32'(x), 32'h6000);
    check("rst_y", 32'(y), 32'h0000);
    check("rst_mac_a", 32'(mac_bus.mac_a), 32'h0);
    check("rst_mac_b", 32'(mac_bus.mac_b), 32'h0);
    check("rst_mac_s", mac_bus.mac_s, 32'h0);
    check("rst_mac_sub", 32'(mac_bus.mac_sub), 32'h0);
    idle(1);

    // Two consecutive steps, with latency and issue-operand checks on the first.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h4000, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0, 16'h0);
    check("iss_x_sub", 32'(mac_bus.mac_sub), 32'h1);
    check("iss_x_a", 32'(mac_bus.mac_a), 32'h0800);
    check("iss_x_s", mac_bus.mac_s, 32'h2000_0000);
    check("lat_busy_n", 32'(busy), 32'h1);
    idle(2);
    check("iss_y_sub", 32'(mac_bus.mac_sub), 32'h0);
    check("iss_y_b", 32'(mac_bus.mac_b), 32'h4000);
    idle(1);
    check("lat_busy_n3", 32'(busy), 32'h1);
    check("lat_valid_n3", 32'(valid), 32'h0);
    idle(1);
    check("step1_valid", 32'(valid), 32'h1);
    check("step1_busy", 32'(busy), 32'h0);
    check("step1_x", 32'(x), 32'h4000);
    check("step1_y", 32'(y), 32'h0400);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0, 16'h0);
    idle(4);
    check("step2_valid", 32'(valid), 32'h1);
    check("step2_x", 32'(x), 32'h3fc0);
    check("step2_y", 32'(y), 32'h07fc);
    check("step2_ov", 32'(overrun), 32'h0);

    // Overrun: tick mid-step, then clear together with an accepted tick.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0, 16'h0);
    idle(1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h7000, 16'h0, 16'h0);
    check("ovr_set", 32'(overrun), 32'h1);
    idle(2);
    check("ovr_valid", 32'(valid), 32'h1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h0, 16'h0);
    check("ovr_clear", 32'(overrun), 32'h0);
    check("ovr_accept", 32'(busy), 32'h1);
    idle(4);

    // Abort by load mid-step.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h2000, 16'h0, 16'h0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h1234, 16'h0abc);
    check("abl_x", 32'(x), 32'h1234);
    check("abl_y", 32'(y), 32'h0abc);
    check("abl_busy", 32'(busy), 32'h0);
    idle(4);

    // Abort by reset mid-step.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h2000, 16'h0, 16'h0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    check("abr_x", 32'(x), 32'h6000);
    check("abr_busy", 32'(busy), 32'h0);
    idle(4);

    // Overflow on the x update.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h7fff, 16'h7fff);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h0, 16'h0);
    idle(4);
`ifdef LISSAJOUS_OSC_SAT_EN
    check("ovf_x", 32'(x), 32'h7fff);
`else
    check("ovf_x", 32'(x), 32'hfffe);
`endif

    // Load and tick together in idle.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h4000, 16'h1111, 16'h2222);
    check("sim_busy", 32'(busy), 32'h0);
    check("sim_ov", 32'(overrun), 32'h0);
    check("sim_x", 32'(x), 32'h1111);
    idle(5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        r_rst;
      logic        r_tick;
      logic        r_load;
      logic        r_clr;
      logic [15:0] r_f;
      r_rst  = ($urandom_range(0, 199) != 0);
      r_tick = ($urandom_range(0, 2) == 0);
      r_load = ($urandom_range(0, 15) == 0);
      r_clr  = ($urandom_range(0, 7) == 0);
      r_f    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095));
      cyc(r_rst, r_tick, r_load, r_clr, r_f, 16'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
